// File: rtl/debounce_sync_if.sv
// Level-conditioning link between a raw input source and the debounce_sync block.
// glitch_cnt exists only when DEBOUNCE_GLITCH_CNT_EN is defined.
interface debounce_sync_if #(
    parameter int GLITCH_W = 8
);
    logic signal_in;
    logic signal_out;
    logic settling;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_cnt;
`endif

    modport master (
        output signal_in,
        input  signal_out,
`ifdef DEBOUNCE_GLITCH_CNT_EN
        input  glitch_cnt,
`endif
        input  settling
    );

    modport slave (
        input  signal_in,
        output signal_out,
`ifdef DEBOUNCE_GLITCH_CNT_EN
        output glitch_cnt,
`endif
        output settling
    );
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus stability counter producing a glitch-free level.
// Optional rejected-glitch counter enabled by defining DEBOUNCE_GLITCH_CNT_EN.
//
// state   | meaning
// IDLE    | cnt == 0, output matches synchronized input or a change was just accepted
// QUALIFY | cnt != 0, synchronized input differs from output and is being timed
module debounce_sync #(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0,
    parameter int   GLITCH_W      = 8
) (
    input logic            clk,
    input logic            rst,
    debounce_sync_if.slave bus
);
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             glitch;
    state_t           state;

    if (STABLE_CYCLES < 1 || GLITCH_W < 1) begin : g_bad_param
        $error("debounce_sync: STABLE_CYCLES and GLITCH_W must be >= 1");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
            level <= RESET_VAL;
            cnt   <= '0;
        end else begin
            sync1 <= bus.signal_in;
            sync2 <= sync1;
            level <= level_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter itself encodes the state; the enum only names it.
    always_comb begin
        state     = (cnt != '0) ? QUALIFY : IDLE;
        level_nxt = level;
        cnt_nxt   = cnt;
        glitch    = 1'b0;
        if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt = sync2;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            cnt_nxt = '0;
            glitch  = (state == QUALIFY);
        end
    end

    assign bus.signal_out = level;
    assign bus.settling   = (state == QUALIFY);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_cnt;

    // Saturates so a noisy line cannot make the count look small again.
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (glitch && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end

    assign bus.glitch_cnt = glitch_cnt;
`else
    logic unused_glitch;
    assign unused_glitch = glitch;
`endif
endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: a cycle model pushes expectations at each edge,
// a negedge monitor pops and compares. Define DEBOUNCE_GLITCH_CNT_EN to cover glitch_cnt.
module tb_debounce_sync;
    localparam int SC = 4;
    localparam int GW = 8;

    typedef struct {
        logic       out;
        logic       settling;
        logic [7:0] gl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debounce_sync_if #(.GLITCH_W(GW)) bus ();

    debounce_sync #(
        .STABLE_CYCLES(SC),
        .RESET_VAL    (1'b0),
        .GLITCH_W     (GW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int    n_tests    = 0;
    int    n_fail     = 0;
    string phase      = "reset";
    logic  saw_settle = 1'b0;
    exp_t  sb[$];

    logic m_s1  = 1'b0;
    logic m_s2  = 1'b0;
    logic m_out = 1'b0;
    int   m_run = 0;
    int   m_gl  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive away from the edge, then advance the reference model at the edge.
    task automatic cyc(input logic din, input logic r);
        exp_t e;
        @(negedge clk);
        #1;
        bus.signal_in = din;
        rst           = r;
        @(posedge clk);
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0; m_run = 0; m_gl = 0;
        end else begin
            if (m_s2 != m_out) begin
                if (m_run == SC - 1) begin
                    m_out = m_s2;
                    m_run = 0;
                end else begin
                    m_run++;
                end
            end else begin
                if (m_run != 0 && m_gl < (1 << GW) - 1) m_gl++;
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = din;
        end
        e.out      = m_out;
        e.settling = (m_run != 0);
        e.gl       = m_gl[7:0];
        sb.push_back(e);
    endtask

    // Counts edges from the one that captures a held 1 until signal_out rises.
    task automatic lat_to_high(input string tag);
        int n;
        n = 0;
        do begin
            cyc(1'b1, 1'b0);
            n++;
            #1;
        end while (bus.signal_out !== 1'b1 && n < 20);
        check_eq(tag, n, SC + 2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.settling === 1'b1) saw_settle = 1'b1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({phase, ".out"}, bus.signal_out, e.out);
            check_eq({phase, ".settling"}, bus.settling, e.settling);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            check_eq({phase, ".glitch_cnt"}, bus.glitch_cnt, e.gl);
`endif
        end
    end

    initial begin
        bus.signal_in = 1'b1;

        phase = "reset";
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        #1;
        check_eq("reset.out_direct", bus.signal_out, 0);
        check_eq("reset.settling_direct", bus.settling, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_eq("reset.glitch_direct", bus.glitch_cnt, 0);
`endif
        repeat (3) cyc(1'b0, 1'b0);

        phase = "rise";
        lat_to_high("rise.latency");
        cyc(1'b1, 1'b0);
        #1;
        check_eq("rise.settling_after", bus.settling, 0);
        repeat (8) cyc(1'b0, 1'b0);

        phase = "glitch";
        saw_settle = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (6) cyc(1'b0, 1'b0);
        #1;
        check_eq("glitch.out_held", bus.signal_out, 0);
        check_eq("glitch.settle_seen", saw_settle, 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_eq("glitch.count", bus.glitch_cnt, 1);
`endif

        phase = "bounce";
        for (int i = 0; i < 20; i++) cyc((i % 2) == 0, 1'b0);
        #1;
        check_eq("bounce.out_held", bus.signal_out, 0);
        lat_to_high("bounce.latency");
        repeat (8) cyc(1'b0, 1'b0);

        phase = "rstmid";
        repeat (3) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        #1;
        check_eq("rstmid.out", bus.signal_out, 0);
        check_eq("rstmid.settling", bus.settling, 0);
        lat_to_high("rstmid.latency");
        repeat (8) cyc(1'b0, 1'b0);

`ifdef DEBOUNCE_GLITCH_CNT_EN
        phase = "sat";
        for (int g = 0; g < 300; g++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b0);
            repeat (3) cyc(1'b0, 1'b0);
        end
        #1;
        check_eq("sat.count", bus.glitch_cnt, 255);
        repeat (2) begin
            cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b0);
            repeat (3) cyc(1'b0, 1'b0);
        end
        #1;
        check_eq("sat.hold", bus.glitch_cnt, 255);
`endif

        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("scoreboard.drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
